// File: rtl/muldiv_pkg.sv
// Shared opcode, state and sizing definitions for the EX-stage multiply/divide unit.
package muldiv_pkg;

    localparam int MD_DATA_WIDTH = 32;
    localparam int MD_MUL_CYCLES = 2;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MADD  = 4'd5;
    localparam logic [3:0] MD_MADDU = 4'd6;
    localparam logic [3:0] MD_MSUB  = 4'd7;
    localparam logic [3:0] MD_MSUBU = 4'd8;
    localparam logic [3:0] MD_MTHI  = 4'd9;
    localparam logic [3:0] MD_MTLO  = 4'd10;
    localparam logic [3:0] MD_MFHI  = 4'd11;
    localparam logic [3:0] MD_MFLO  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DIV_FIX
    } md_state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Latency: start edge loads, W step cycles, done high the cycle after the last step.
// Backpressure: none; start restarts the divider unconditionally.
module muldiv_divider
    import muldiv_pkg::*;
#(
    parameter int W = MD_DATA_WIDTH
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [W:0]    shifted;
    logic          ge;

    always_comb begin
        // Dividend bits stream out of the quotient register's MSB into the partial remainder.
        shifted = {rem_q, quo_q[W-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            rem_d  = ge ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
            quo_d  = {quo_q[W-2:0], ge};
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; MTHI/MTLO write at issue.
// Latency: multiply class MUL_CYCLES busy cycles, divide class 33 busy cycles.
// Backpressure: ALU_Stall holds EX while busy; Hold/Flush only block issue.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH,
    parameter int MUL_CYCLES = MD_MUL_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [3:0]            Op,
    input  logic                  Hold,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] Rs_Data,
    input  logic [DATA_WIDTH-1:0] Rt_Data,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  ALU_Stall,
    output logic                  Busy
);

    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (MUL_CYCLES > W) ? MUL_CYCLES : W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, rs_q, rs_d, rt_q, rt_d;
    logic [3:0]       op_q, op_d;

    logic             op_vld, op_any, issue, div_signed, mul_signed;
    logic             div_start, div_done;
    logic [W-1:0]     rs_mag, rt_mag, div_quo, div_rem, quo_fix, rem_fix;
    logic [2*W-1:0]   mul_a, mul_b, mul_prod, mul_res;

    assign op_vld    = (Op >= MD_MULT) && (Op <= MD_MTLO);
    assign op_any    = (Op >= MD_MULT) && (Op <= MD_MFLO);
    assign Busy      = (state_q != ST_IDLE);
    assign ALU_Stall = Busy && op_any;
    assign issue     = (state_q == ST_IDLE) && op_vld && !Hold && !Flush;

    // Divider sees magnitudes only; signs are reapplied in DIV_FIX.
    assign div_signed = (Op == MD_DIV);
    assign rs_mag     = (div_signed && Rs_Data[W-1]) ? -Rs_Data : Rs_Data;
    assign rt_mag     = (div_signed && Rt_Data[W-1]) ? -Rt_Data : Rt_Data;

    assign mul_signed = (op_q == MD_MULT) || (op_q == MD_MADD) || (op_q == MD_MSUB);
    assign mul_a      = mul_signed ? {{W{rs_q[W-1]}}, rs_q} : {{W{1'b0}}, rs_q};
    assign mul_b      = mul_signed ? {{W{rt_q[W-1]}}, rt_q} : {{W{1'b0}}, rt_q};
    assign mul_prod   = mul_a * mul_b;

    always_comb begin
        case (op_q)
            MD_MADD, MD_MADDU: mul_res = {hi_q, lo_q} + mul_prod;
            MD_MSUB, MD_MSUBU: mul_res = {hi_q, lo_q} - mul_prod;
            default:           mul_res = mul_prod;
        endcase
        quo_fix = div_quo;
        rem_fix = div_rem;
        if (op_q == MD_DIV) begin
            quo_fix = (rs_q[W-1] ^ rt_q[W-1]) ? -div_quo : div_quo;
            rem_fix = rs_q[W-1] ? -div_rem : div_rem;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    op_d = Op;
                    rs_d = Rs_Data;
                    rt_d = Rt_Data;
                    case (Op)
                        MD_MTHI: hi_d = Rs_Data;
                        MD_MTLO: lo_d = Rs_Data;
                        MD_DIV, MD_DIVU: begin
                            state_d   = ST_DIV;
                            cnt_d     = CNT_W'(W - 1);
                            div_start = 1'b1;
                        end
                        default: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // Zero divisor bypasses the divider result so HI keeps the raw dividend.
                if (div_done) begin
                    if (rt_q == '0) begin
                        hi_d = rs_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MD_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    muldiv_divider #(.W(W)) u_divider (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a cycle-level reference model checked every cycle.
module tb_muldiv_unit;

    localparam int MUL_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  Op;
    logic        Hold, Flush;
    logic [31:0] Rs_Data, Rt_Data, HI, LO;
    logic        ALU_Stall, Busy;

    always #5 clock = ~clock;

    muldiv_unit #(.DATA_WIDTH(32), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Op        (Op),
        .Hold      (Hold),
        .Flush     (Flush),
        .Rs_Data   (Rs_Data),
        .Rt_Data   (Rt_Data),
        .HI        (HI),
        .LO        (LO),
        .ALU_Stall (ALU_Stall),
        .Busy      (Busy)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic logic [63:0] m_mul(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb, p;
        if (op == 4'd1 || op == 4'd5 || op == 4'd7) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        p = sa * sb;
        if (op == 4'd5 || op == 4'd6) return acc + 64'(p);
        if (op == 4'd7 || op == 4'd8) return acc - 64'(p);
        return 64'(p);
    endfunction

    function automatic logic [63:0] m_div(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 4'd3) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (Op >= 4'd1 && Op <= 4'd10 && !Hold && !Flush) begin
            case (Op)
                4'd9:  m_hi <= Rs_Data;
                4'd10: m_lo <= Rs_Data;
                4'd3, 4'd4: begin
                    {p_hi, p_lo} <= m_div(Op, Rs_Data, Rt_Data);
                    m_left       <= 33;
                end
                default: begin
                    {p_hi, p_lo} <= m_mul(Op, Rs_Data, Rt_Data, {m_hi, m_lo});
                    m_left       <= MUL_CYCLES;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_busy", 32'(Busy), 32'(m_left != 0));
            check("model_stall", 32'(ALU_Stall), 32'((m_left != 0) && Op >= 4'd1 && Op <= 4'd12));
            check("model_hi", HI, m_hi);
            check("model_lo", LO, m_lo);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents op for one cycle, then 'during' while waiting for Busy to fall.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [3:0] during, output int bc);
        Op      = op;
        Rs_Data = rs;
        Rt_Data = rt;
        step();
        Op = during;
        bc = 0;
        while (Busy === 1'b1 && bc < 100) begin
            bc++;
            step();
        end
        if (bc >= 100) begin
            checks++;
            errors++;
            $display("FAIL run_timeout op=%0d busy_cycles=%0d limit=100", op, bc);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        reset_n = 1'b0;
        Op      = 4'd0;
        Hold    = 1'b0;
        Flush   = 1'b0;
        Rs_Data = '0;
        Rt_Data = '0;
        repeat (2) step();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        Op      = 4'd11;
        #1;
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_idle_mfhi_stall", 32'(ALU_Stall), 32'd0);

        // MULT -2 * 3 with MFLO waiting behind it
        step();
        Op = 4'd1; Rs_Data = 32'hFFFF_FFFE; Rt_Data = 32'd3;
        step();
        Op = 4'd12; #1;
        check("mult_stall_n1", 32'(ALU_Stall), 32'd1);
        step();
        check("mult_stall_n2", 32'(ALU_Stall), 32'd1);
        step();
        check("mult_stall_n3", 32'(ALU_Stall), 32'd0);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        check("mult_hi", HI, 32'hFFFF_FFFF);

        run_op(4'd4, 32'd100, 32'd7, 4'd12, bc);
        check("divu_busy_cycles", 32'(bc), 32'd33);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0, bc);
        check("div_neg_lo", LO, 32'hFFFF_FFFD);
        check("div_neg_hi", HI, 32'hFFFF_FFFF);

        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 4'd0, bc);
        check("div_negdvs_lo", LO, 32'hFFFF_FFFD);
        check("div_negdvs_hi", HI, 32'd1);

        run_op(4'd3, 32'h1234_5678, 32'd0, 4'd11, bc);
        check("div0_busy_cycles", 32'(bc), 32'd33);
        check("div0_lo", LO, 32'hFFFF_FFFF);
        check("div0_hi", HI, 32'h1234_5678);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, bc);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'd0);

        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, bc);
        check("multu_busy_cycles", 32'(bc), 32'(MUL_CYCLES));
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'd1);

        run_op(4'd9, 32'd1, 32'd0, 4'd0, bc);
        check("mthi_busy_cycles", 32'(bc), 32'd0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd0, 4'd0, bc);
        check("mthi_hi", HI, 32'd1);
        check("mtlo_lo", LO, 32'hFFFF_FFFF);
        run_op(4'd6, 32'd1, 32'd1, 4'd0, bc);
        check("maddu_hi", HI, 32'd2);
        check("maddu_lo", LO, 32'd0);
        run_op(4'd7, 32'd1, 32'd1, 4'd0, bc);
        check("msub_hi", HI, 32'd1);
        check("msub_lo", LO, 32'hFFFF_FFFF);

        // Hold then Flush block issue; Hold during MUL does not move completion
        Op = 4'd1; Rs_Data = 32'd5; Rt_Data = 32'hFFFF_FFFC; Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_no_issue", 32'(Busy), 32'd0);
        end
        Hold = 1'b0; Flush = 1'b1;
        step();
        check("flush_no_issue", 32'(Busy), 32'd0);
        Flush = 1'b0;
        step();
        check("issue_after_release", 32'(Busy), 32'd1);
        Op = 4'd0; Hold = 1'b1;
        step();
        check("hold_mul_n2_busy", 32'(Busy), 32'd1);
        Hold = 1'b0;
        step();
        Hold = 1'b1; #1;
        check("hold_mul_n3_idle", 32'(Busy), 32'd0);
        check("hold_mul_hi", HI, 32'hFFFF_FFFF);
        check("hold_mul_lo", LO, 32'hFFFF_FFEC);
        Hold = 1'b0;

        // Back-to-back: MADDU waits behind MULTU and accumulates onto its result
        Op = 4'd2; Rs_Data = 32'd2; Rt_Data = 32'd3;
        step();
        Op = 4'd6; Rs_Data = 32'd1; Rt_Data = 32'd1; #1;
        check("b2b_stall", 32'(ALU_Stall), 32'd1);
        step();
        step();
        check("b2b_idle_busy", 32'(Busy), 32'd0);
        check("b2b_mid_lo", LO, 32'd6);
        step();
        Op = 4'd0;
        check("b2b_madd_busy", 32'(Busy), 32'd1);
        step();
        step();
        check("b2b_done_busy", 32'(Busy), 32'd0);
        check("b2b_hi", HI, 32'd0);
        check("b2b_lo", LO, 32'd7);

        // Reset at cycle N+10 of a DIV
        Op = 4'd3; Rs_Data = 32'd100; Rt_Data = 32'd3;
        step();
        Op = 4'd11;
        repeat (9) step();
        check("rstdiv_busy_before", 32'(Busy), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; #1;
        check("rstdiv_busy", 32'(Busy), 32'd0);
        check("rstdiv_stall", 32'(ALU_Stall), 32'd0);
        check("rstdiv_hi", HI, 32'd0);
        check("rstdiv_lo", LO, 32'd0);

        run_op(4'd4, 32'd50, 32'd5, 4'd0, bc);
        check("post_rst_divu_lo", LO, 32'd10);
        check("post_rst_divu_hi", HI, 32'd0);

        repeat (2) step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
